// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-style modulo counter: the {j,k} mode encodings
// and a small helper that forms the mode word from the two control pins.
package jk_counter_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_UP   = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   function automatic logic [1:0] mode_of(input logic j, input logic k);
      return {j, k};
   endfunction

endpackage

// File: rtl/jk_cnt_next.sv
// Combinational next-state logic for the modulo counter: next count plus the
// wrap and load_err flags that the top registers on each falling edge.
module jk_cnt_next
   import jk_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   input  logic             pr,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] q_next,
   output logic             wrap_next,
   output logic             load_err_next
);

   localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
   // One extra bit so MODULUS = 2**WIDTH is representable for the range test.
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

   logic [WIDTH:0] d_ext;

   assign d_ext = {1'b0, d};

   always_comb begin
      q_next        = q;
      wrap_next     = 1'b0;
      load_err_next = 1'b0;
      if (pr) begin
         q_next = MAX_Q;
      end else if (en) begin
         case (mode)
            MODE_UP: begin
               if (q == MAX_Q) begin
                  q_next    = '0;
                  wrap_next = 1'b1;
               end else begin
                  q_next = q + 1'b1;
               end
            end
            MODE_DOWN: begin
               if (q == '0) begin
                  q_next    = MAX_Q;
                  wrap_next = 1'b1;
               end else begin
                  q_next = q - 1'b1;
               end
            end
            MODE_LOAD: begin
               // Out-of-range loads saturate to the top of the count range.
               if (d_ext >= MOD_EXT) begin
                  q_next        = MAX_Q;
                  load_err_next = 1'b1;
               end else begin
                  q_next = d;
               end
            end
            default: begin
               q_next = q;
            end
         endcase
      end
   end

endmodule

// File: rtl/jk_mod_counter.sv
// Falling-edge modulo counter with JK-style mode select, synchronous preset,
// parallel load and an asynchronous clear; registers q, wrap and load_err.
module jk_mod_counter
   import jk_counter_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 10
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             pr,
   input  logic             en,
   input  logic             j,
   input  logic             k,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nq,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

   if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_params
      $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
   end

   logic [1:0]       mode;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;
   logic             load_err_next;

   assign mode = mode_of(j, k);

   jk_cnt_next #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_next (
      .q             (q),
      .d             (d),
      .pr            (pr),
      .en            (en),
      .mode          (mode),
      .q_next        (q_next),
      .wrap_next     (wrap_next),
      .load_err_next (load_err_next)
   );

   always_ff @(negedge clk or posedge clr) begin
      if (clr) begin
         q        <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         q        <= q_next;
         wrap     <= wrap_next;
         load_err <= load_err_next;
      end
   end

   // Terminal count looks ahead at the pending edge, so preset masks it.
   assign tc = en & ~pr & (((mode == MODE_UP) & (q == MAX_Q)) |
                           ((mode == MODE_DOWN) & (q == '0)));

   assign nq = ~q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench for jk_mod_counter: directed scenarios followed by a
// randomized run compared against a modular-arithmetic reference model.
module tb_jk_mod_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 10;

   logic             clk = 1'b0;
   logic             clr;
   logic             pr;
   logic             en;
   logic             j;
   logic             k;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] nq;
   logic             tc;
   logic             wrap;
   logic             load_err;

   int checks   = 0;
   int failures = 0;

   int modelQ;
   int modelWrap;
   int modelErr;

   jk_mod_counter #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .pr       (pr),
      .en       (en),
      .j        (j),
      .k        (k),
      .d        (d),
      .q        (q),
      .nq       (nq),
      .tc       (tc),
      .wrap     (wrap),
      .load_err (load_err)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic compareState(input string tag);
      checkOutput({tag, ".q"}, 32'(q), 32'(modelQ));
      checkOutput({tag, ".nq"}, 32'(nq), 32'((~modelQ) & 32'hF));
      checkOutput({tag, ".wrap"}, 32'(wrap), 32'(modelWrap));
      checkOutput({tag, ".load_err"}, 32'(load_err), 32'(modelErr));
      checkOutput({tag, ".range"}, 32'(q < MODULUS), 32'd1);
   endtask

   // Called just after a falling edge; drives one operation and checks it.
   task automatic applyStimulus(input string tag, input logic p, input logic e,
                                input logic jj, input logic kk, input logic [WIDTH-1:0] dd);
      int expTc;
      pr = p;
      en = e;
      j  = jj;
      k  = kk;
      d  = dd;
      #1;
      expTc = (e && !p && ((jj && !kk && modelQ == MODULUS - 1) ||
                           (!jj && kk && modelQ == 0))) ? 1 : 0;
      checkOutput({tag, ".tc"}, 32'(tc), 32'(expTc));
      @(negedge clk);
      #1;
      modelWrap = 0;
      modelErr  = 0;
      if (p) begin
         modelQ = MODULUS - 1;
      end else if (e) begin
         if (jj && !kk) begin
            modelWrap = (modelQ == MODULUS - 1) ? 1 : 0;
            modelQ    = (modelQ + 1) % MODULUS;
         end else if (!jj && kk) begin
            modelWrap = (modelQ == 0) ? 1 : 0;
            modelQ    = (modelQ + MODULUS - 1) % MODULUS;
         end else if (jj && kk) begin
            if (int'(dd) >= MODULUS) begin
               modelQ   = MODULUS - 1;
               modelErr = 1;
            end else begin
               modelQ = int'(dd);
            end
         end
      end
      compareState(tag);
   endtask

   // Asynchronous clear pulse strictly between falling edges.
   task automatic pulseClear(input string tag);
      clr = 1'b1;
      #2;
      modelQ    = 0;
      modelWrap = 0;
      modelErr  = 0;
      compareState(tag);
      clr = 1'b0;
      #1;
   endtask

   initial begin
      clr = 1'b1;
      pr  = 1'b0;
      en  = 1'b0;
      j   = 1'b0;
      k   = 1'b0;
      d   = '0;
      modelQ    = 0;
      modelWrap = 0;
      modelErr  = 0;
      #3;
      compareState("reset");
      clr = 1'b0;

      for (int i = 0; i < 10; i++) applyStimulus("up", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
      applyStimulus("down_from0", 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
      applyStimulus("load6", 1'b0, 1'b1, 1'b1, 1'b1, 4'd6);
      applyStimulus("load12", 1'b0, 1'b1, 1'b1, 1'b1, 4'd12);
      applyStimulus("err_clear", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      applyStimulus("load15", 1'b0, 1'b1, 1'b1, 1'b1, 4'd15);
      applyStimulus("load3", 1'b0, 1'b1, 1'b1, 1'b1, 4'd3);
      applyStimulus("preset", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 3; i++) applyStimulus("hold_en0", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      applyStimulus("load7", 1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
      pulseClear("clr_at7");
      applyStimulus("after_clr", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

      clr = 1'b1;
      pr  = 1'b1;
      @(negedge clk);
      #1;
      modelQ    = 0;
      modelWrap = 0;
      modelErr  = 0;
      compareState("clr_over_pr");
      clr = 1'b0;
      pr  = 1'b0;

      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 39) == 0) pulseClear("rand_clr");
         applyStimulus("rand",
                       ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)),
                       4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
